// File: rtl/b_dly_cal.sv
// Delay-line calibration controller: sweeps the select code upward until the
// line delay reaches one clock period, then parks the line on that code.
`timescale 1ns/1ps
module b_dly_cal #(
    parameter int SETTLE_CYC = 4,
    parameter int NUM_AVG    = 8,
    parameter int HIT_TH     = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_dly_out,
    output logic       o_dly_in,
    output logic [7:0] o_dly_sel,
    output logic [7:0] o_lock_code,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, CAPT, SYNC, EVAL, DONE} state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [7:0]  NAVG        = 8'(NUM_AVG);
    localparam logic [7:0]  HTH         = 8'(HIT_TH);

    state_t      state_q, state_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  trial_q, trial_d;
    logic [7:0]  hits_q, hits_d;
    logic [15:0] scnt_q, scnt_d;
    logic        sph_q, sph_d;
    logic        capt_q, sync_q;
    logic        dly_in_q, dly_in_d;
    logic [7:0]  sel_q, sel_d;
    logic [7:0]  lock_q, lock_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        trial_d  = trial_q;
        hits_d   = hits_q;
        scnt_d   = '0;
        sph_d    = 1'b0;
        dly_in_d = 1'b0;
        lock_d   = lock_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    code_d  = '0;
                    trial_d = '0;
                    hits_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (scnt_q == SETTLE_LAST) state_d = LAUNCH;
                else                       scnt_d  = scnt_q + 16'd1;
            end
            // Launch edge is registered so it rises at the start of CAPT,
            // exactly one period before the capture edge.
            LAUNCH: begin
                dly_in_d = 1'b1;
                state_d  = CAPT;
            end
            CAPT: begin
                dly_in_d = 1'b1;
                state_d  = SYNC;
            end
            SYNC: begin
                if (!sph_q) begin
                    sph_d = 1'b1;
                end else begin
                    if (sync_q && (hits_q != 8'hFF)) hits_d = hits_q + 8'd1;
                    trial_d = trial_q + 8'd1;
                    state_d = (trial_d < NAVG) ? SETTLE : EVAL;
                end
            end
            EVAL: begin
                if (hits_q < HTH) begin
                    lock_d  = code_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (code_q == 8'hFF) begin
                    lock_d  = 8'hFF;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    code_d  = code_q + 8'd1;
                    trial_d = '0;
                    hits_d  = '0;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
        sel_d = (state_d == DONE) ? lock_d : code_d;
    end

    // capt_q is the possibly-metastable sampler; sync_q resolves it before use.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            code_q   <= '0;
            trial_q  <= '0;
            hits_q   <= '0;
            scnt_q   <= '0;
            sph_q    <= 1'b0;
            capt_q   <= 1'b0;
            sync_q   <= 1'b0;
            dly_in_q <= 1'b0;
            sel_q    <= '0;
            lock_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            trial_q  <= trial_d;
            hits_q   <= hits_d;
            scnt_q   <= scnt_d;
            sph_q    <= sph_d;
            if (state_q == CAPT) capt_q <= i_dly_out;
            sync_q   <= capt_q;
            dly_in_q <= dly_in_d;
            sel_q    <= sel_d;
            lock_q   <= lock_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_dly_in    = dly_in_q;
    assign o_dly_sel   = sel_q;
    assign o_lock_code = lock_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_b_dly_cal.sv
// Bench for b_dly_cal: a delay-line model (physical or per-code hit table)
// drives i_dly_out; expected lock codes come from scanning the model's rules.
`timescale 1ns/1ps
module tb_b_dly_cal;

    localparam int SETTLE_CYC = 4;
    localparam int NUM_AVG    = 8;
    localparam int HIT_TH     = 4;
    localparam int PERIOD_PS  = 10000;
    localparam int CODE_CYC   = NUM_AVG * (SETTLE_CYC + 4) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       dly_out = 1'b0;
    logic       dly_in;
    logic [7:0] dly_sel;
    logic [7:0] lock_code;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad = 0;
    int mode = 0;
    int base_ps = 200;
    int step_ps = 100;
    int tbl[256];
    int last_sel = -1;
    int trial_idx = 0;
    int last_d = 0;
    int busy_cnt = 0;
    bit spam = 1'b0;

    always #5 clk = ~clk;

    b_dly_cal #(.SETTLE_CYC(SETTLE_CYC), .NUM_AVG(NUM_AVG), .HIT_TH(HIT_TH)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_dly_out(dly_out),
        .o_dly_in(dly_in),
        .o_dly_sel(dly_sel),
        .o_lock_code(lock_code),
        .o_busy(busy),
        .o_done(done),
        .o_err(err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Delay-line model: mode 0 is delay = base + step*code (ps); mode 1 hits
    // on the first tbl[code] trials of each code and misses on the rest.
    always @(posedge dly_in) begin
        int d;
        if (int'(dly_sel) != last_sel) begin
            last_sel  = int'(dly_sel);
            trial_idx = 0;
        end
        if (mode == 0) begin
            d = base_ps + step_ps * int'(dly_sel);
            if (d == PERIOD_PS) d = PERIOD_PS + 1;
        end else begin
            d = (trial_idx < tbl[dly_sel]) ? 3000 : 13000;
        end
        trial_idx++;
        last_d = (mode == 0) ? d : 3000;
        fork
            begin : rise_p
                automatic int dd = d;
                #(real'(dd) / 1000.0) dly_out = 1'b1;
            end
        join_none
    end

    always @(negedge dly_in) begin
        fork
            begin : fall_p
                automatic int dd = last_d;
                #(real'(dd) / 1000.0) dly_out = 1'b0;
            end
        join_none
    end

    // Line-interface monitor.
    logic       prev_in = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] prev_sel = '0;
    logic [7:0] rise_sel = '0;
    int lowrun = 0, highrun = 0, stable = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_in = 1'b0; prev_busy = 1'b0; lowrun = 0; highrun = 0; stable = 0;
        end else begin
            if (dly_sel == prev_sel) stable++; else stable = 1;
            if (dly_in && !prev_in) begin
                check("settle_low_min", (lowrun < SETTLE_CYC + 1) ? lowrun : SETTLE_CYC + 1, SETTLE_CYC + 1);
                check("sel_stable_min", (stable < SETTLE_CYC + 2) ? stable : SETTLE_CYC + 2, SETTLE_CYC + 2);
                check("launch_busy", int'(busy), 1);
                rise_sel = dly_sel;
                highrun  = 0;
            end
            if (!dly_in && prev_in) check("high_len", highrun, 2);
            if (dly_in) begin
                highrun++;
                lowrun = 0;
                check("sel_hold_high", int'(dly_sel), int'(rise_sel));
            end else begin
                lowrun++;
            end
            if (busy && prev_busy && dly_sel != prev_sel)
                check("code_step", int'(dly_sel), int'(prev_sel) + 1);
            if (busy) busy_cnt++;
            prev_in   = dly_in;
            prev_busy = busy;
            prev_sel  = dly_sel;
        end
    end

    function automatic int ref_phys();
        for (int c = 0; c < 256; c++)
            if (base_ps + step_ps * c >= PERIOD_PS) return c;
        return 256;
    endfunction

    function automatic int ref_tbl();
        for (int c = 0; c < 256; c++)
            if (tbl[c] < HIT_TH) return c;
        return 256;
    endfunction

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1; last_sel = -1; busy_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_done_clr", int'(done), 0);
        check("start_err_clr", int'(err), 0);
        check("start_sel0", int'(dly_sel), 0);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(posedge clk); #1;
            start = spam && (n % 401 == 7);
            n++;
        end
        start = 1'b0;
        check("sweep_timeout", int'(busy), 0);
    endtask

    task automatic sweep(input string tag, input int ref_code);
        int exp_lock = (ref_code > 255) ? 255 : ref_code;
        int exp_err  = (ref_code > 255) ? 1 : 0;
        do_start();
        wait_done(20000);
        check({tag, "_lock"}, int'(lock_code), exp_lock);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_err"}, int'(err), exp_err);
        check({tag, "_sel"}, int'(dly_sel), exp_lock);
        check({tag, "_busycyc"}, busy_cnt, (exp_lock + 1) * CODE_CYC);
    endtask

    initial begin
        int tgt;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dly_in", int'(dly_in), 0);
        check("rst_sel", int'(dly_sel), 0);
        check("rst_lock", int'(lock_code), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;

        mode = 0; base_ps = 200; step_ps = 100;
        sweep("nominal", ref_phys());
        check("nominal_is98", ref_phys(), 98);

        base_ps = 0; step_ps = 10; spam = 1'b1;
        sweep("nohit", ref_phys());
        spam = 1'b0;

        mode = 1;
        for (int c = 0; c < 256; c++) tbl[c] = (c < 40) ? NUM_AVG : 0;
        tbl[40] = 3;
        sweep("jit3", ref_tbl());
        tbl[40] = 4; tbl[41] = 0;
        sweep("jit4", ref_tbl());

        for (int k = 0; k < 3; k++) begin
            tgt = $urandom_range(5, 60);
            for (int c = 0; c < 256; c++) begin
                if (c < tgt)       tbl[c] = $urandom_range(HIT_TH, NUM_AVG);
                else if (c == tgt) tbl[c] = $urandom_range(0, HIT_TH - 1);
                else               tbl[c] = $urandom_range(0, NUM_AVG);
            end
            sweep("rand", ref_tbl());
        end

        mode = 0; base_ps = 200; step_ps = 100;
        do_start();
        n = 0;
        while (!(dly_sel == 8'd50 && dly_in) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("reach_code50", int'(dly_sel), 50);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_dly_in", int'(dly_in), 0);
        check("arst_sel", int'(dly_sel), 0);
        check("arst_lock", int'(lock_code), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_err", int'(err), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        sweep("post_rst", ref_phys());

        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_start_busy", int'(busy), 0);
        check("rst_start_done", int'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
